// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver (8N1, LSB first).
// Start-bit validation, 3-sample majority vote around mid-bit,
// framing-error and overrun reporting, valid/ready byte output.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | line idle, watching for a falling edge on rxd
// START     | validating the start bit at its mid-point
// DATA      | sampling the 8 data bits, LSB first
// STOP      | sampling the stop bit; completion or framing error
// WAIT_HIGH | after a framing error, holding off until the line is high
module uart_rx_os #(
    parameter int CLK_FREQ = 65_000_000,
    parameter int UART_BPS = 9600,
    parameter int OS_DIV   = CLK_FREQ / (UART_BPS * 16)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CW-1:0] OS_LAST = CW'(OS_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rxd_m;
    logic          rxd_s;
    logic          rxd_d;
    logic [CW-1:0] os_cnt;
    logic [3:0]    smp;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          v7;
    logic          v8;

    logic os_tick;
    logic vote_tick;
    logic wrap_tick;
    logic vote;
    logic start_edge;

    assign os_tick    = (os_cnt == OS_LAST);
    assign vote_tick  = os_tick && (smp == 4'd9);
    assign wrap_tick  = os_tick && (smp == 4'd15);
    // Third sample is taken live on the sample-9 tick itself.
    assign vote       = (v7 & v8) | (v7 & rxd_s) | (v8 & rxd_s);
    assign start_edge = (state == IDLE) && rxd_d && !rxd_s;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    // Oversample tick and sample index, re-phased to the detected start edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            os_cnt <= '0;
            smp    <= 4'd0;
        end else if (start_edge) begin
            os_cnt <= '0;
            smp    <= 4'd0;
        end else if (os_tick) begin
            os_cnt <= '0;
            smp    <= smp + 4'd1;
        end else begin
            os_cnt <= os_cnt + 1'b1;
        end
    end

    // Capture the two early samples of the majority vote.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v7 <= 1'b0;
            v8 <= 1'b0;
        end else if (os_tick) begin
            if (smp == 4'd7) v7 <= rxd_s;
            if (smp == 4'd8) v8 <= rxd_s;
        end
    end

    // Receive FSM with registered status outputs and the output byte register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A completion in the same cycle overrides this clear below.
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (vote_tick && vote) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wrap_tick) begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                    end
                end
                DATA: begin
                    if (vote_tick) shreg <= {vote, shreg[7:1]};
                    if (wrap_tick) begin
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (vote_tick) begin
                        if (vote) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state     <= WAIT_HIGH;
                            frame_err <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scenario-driven bench for uart_rx_os at 160 clocks per bit.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 1_600_000;
    localparam int UART_BPS = 10_000;
    localparam int OSD      = 10;
    localparam int BIT      = 16 * OSD;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_fe = 0;
    int n_ov = 0;
    int n_busy = 0;
    int t_fall = 0;
    int t_rise = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q[$];

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle; record transfers, pulses and busy duration.
    always @(negedge sys_clk) begin
        if (rx_valid) n_valid++;
        if (rx_valid && !prev_valid) t_rise = cyc;
        prev_valid = rx_valid;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (busy) n_busy++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_obs();
        n_valid = 0;
        n_fe = 0;
        n_ov = 0;
        n_busy = 0;
        got_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_v);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        t_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            idle(bl);
        end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp_q[$]);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s byte %0d: got %02h, expected %02h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b busy=%b, expected all 0",
                     rx_data, rx_valid, frame_err, overrun, busy);
        end
        sys_rst = 1'b0;
        idle(30);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b valid=%b, expected 0 0", busy, rx_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_q[$];
        int lat;
        rx_ready = 1'b1;
        clear_obs();
        send_frame(8'h55, BIT, 1'b1);
        lat = t_rise - t_fall;
        checks++;
        // 3 cycles to edge detect, stop vote (16*9+10)*OSD later, valid one cycle after.
        if (lat != 3 + (16 * 9 + 10) * OSD) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, expected %0d", lat, 3 + (16 * 9 + 10) * OSD);
        end
        idle(20);
        send_frame(8'hA3, BIT, 1'b1);
        idle(20);
        exp_q = '{8'h55, 8'hA3};
        check_bytes("basic", exp_q);
        checks++;
        if (n_valid != 2 || n_fe != 0 || n_ov != 0) begin
            failures++;
            $display("FAIL basic_pulses: got valid_cycles=%0d fe=%0d ov=%0d, expected 2 0 0",
                     n_valid, n_fe, n_ov);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q[$];
        rx_ready = 1'b0;
        clear_obs();
        send_frame(8'h3C, BIT, 1'b1);
        idle(20);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            failures++;
            $display("FAIL overrun_first: got v=%b data=%02h, expected 1 3c", rx_valid, rx_data);
        end
        send_frame(8'h0F, BIT, 1'b1);
        idle(20);
        checks++;
        if (n_ov != 1 || rx_data !== 8'h3C || rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold: got ov=%0d data=%02h v=%b, expected 1 3c 1",
                     n_ov, rx_data, rx_valid);
        end
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(2);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drain: got v=%b, expected 0", rx_valid);
        end
        exp_q = '{8'h3C};
        check_bytes("overrun", exp_q);
    endtask

    task automatic test_glitch();
        logic [7:0] exp_q[$];
        rx_ready = 1'b1;
        clear_obs();
        uart_rxd = 1'b0;
        idle(50);
        uart_rxd = 1'b1;
        idle(200);
        checks++;
        // busy spans edge detect to the start-bit vote: 10 ticks of OSD cycles.
        if (n_busy != 10 * OSD || busy !== 1'b0 || n_valid != 0 || n_fe != 0 || n_ov != 0) begin
            failures++;
            $display("FAIL glitch: got busy_cycles=%0d busy=%b valid=%0d fe=%0d ov=%0d, expected %0d 0 0 0 0",
                     n_busy, busy, n_valid, n_fe, n_ov, 10 * OSD);
        end
        send_frame(8'h81, BIT, 1'b1);
        idle(20);
        exp_q = '{8'h81};
        check_bytes("glitch_next", exp_q);
    endtask

    task automatic test_frame_err();
        logic [7:0] exp_q[$];
        rx_ready = 1'b1;
        clear_obs();
        send_frame(8'hE7, BIT, 1'b0);
        idle(3 * BIT);
        checks++;
        if (n_fe != 1 || n_valid != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL frame_err_low: got fe=%0d valid=%0d busy=%b, expected 1 0 1", n_fe, n_valid, busy);
        end
        uart_rxd = 1'b1;
        idle(5);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_release: got busy=%b, expected 0", busy);
        end
        idle(20);
        send_frame(8'h42, BIT, 1'b1);
        idle(20);
        exp_q = '{8'h42};
        check_bytes("frame_err_next", exp_q);
        checks++;
        if (n_fe != 1) begin
            failures++;
            $display("FAIL frame_err_count: got %0d, expected 1", n_fe);
        end
    endtask

    task automatic test_baud_tol();
        logic [7:0] exp_q[$];
        rx_ready = 1'b1;
        clear_obs();
        send_frame(8'hC9, BIT - 5, 1'b1);
        idle(20);
        send_frame(8'hC9, BIT + 5, 1'b1);
        idle(20);
        exp_q = '{8'hC9, 8'hC9};
        check_bytes("baud_tol", exp_q);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_q[$];
        rx_ready = 1'b1;
        clear_obs();
        fork
            send_frame(8'hB4, BIT, 1'b1);
            begin
                idle(5 * BIT + BIT / 2);
                sys_rst = 1'b1;
                #1;
                checks++;
                if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
                    failures++;
                    $display("FAIL reset_mid_outputs: got data=%02h v=%b fe=%b ov=%b busy=%b, expected all 0",
                             rx_data, rx_valid, frame_err, overrun, busy);
                end
            end
        join
        idle(5);
        sys_rst = 1'b0;
        idle(20);
        checks++;
        if (n_valid != 0 || n_fe != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort: got valid=%0d fe=%0d busy=%b, expected 0 0 0", n_valid, n_fe, busy);
        end
        send_frame(8'h7E, BIT, 1'b1);
        idle(20);
        exp_q = '{8'h7E};
        check_bytes("reset_mid_next", exp_q);
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        rx_ready = 1'b1;
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, $urandom_range(BIT - 4, BIT + 4), 1'b1);
            idle($urandom_range(5, 40));
        end
        check_bytes("random", exp_q);
        checks++;
        if (n_fe != 0 || n_ov != 0) begin
            failures++;
            $display("FAIL random_flags: got fe=%0d ov=%0d, expected 0 0", n_fe, n_ov);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_baud_tol();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
